// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small operation-decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Bit 1 of the op code selects divide, bit 0 selects signed.
    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter_div_step.sv
// One restoring radix-2 division step on a packed {rem, quo} pair:
// shift left by one, subtract the divisor when it fits, and record the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] rem_quo,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] rem_quo_next
);

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;

    // The shifted remainder is W+1 bits wide; any difference is below the divisor, so W bits suffice.
    always_comb begin
        rem_sh_s = rem_quo[2*WIDTH-1:WIDTH-1];
        ge_s     = (rem_sh_s >= {1'b0, divisor});
        diff_s   = rem_sh_s[WIDTH-1:0] - divisor;
        if (ge_s) begin
            rem_quo_next = {diff_s, rem_quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_quo_next = {rem_sh_s[WIDTH-1:0], rem_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle signed/unsigned multiply/divide with start/done handshake and annul.
// Define MULDIV_FAST_MUL_EN to compute multiplies combinationally in PREP.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o
);

    state_e               state_r, state_s;
    op_e                  op_r;
    logic [WIDTH-1:0]     a_r, b_r, opb_mag_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 sign_q_r, sign_rem_r;
    logic                 busy_r, done_r;
    logic [2*WIDTH-1:0]   result_r;

    logic                 sign_mode_s, div0_s, fast_mul_s;
    logic [WIDTH-1:0]     mag_a_s, mag_b_s, quo_fix_s, rem_fix_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   div_next_s, mul_next_s, step_s, fix_s, fast_prod_s, result_s;

    // Operand magnitudes and the divide-by-zero decode, both taken from the latched request.
    always_comb begin
        sign_mode_s = is_signed_op(op_r);
        div0_s      = is_div(op_r) && (b_r == {WIDTH{1'b0}});
        if (sign_mode_s && a_r[WIDTH-1]) begin
            mag_a_s = -a_r;
        end else begin
            mag_a_s = a_r;
        end
        if (sign_mode_s && b_r[WIDTH-1]) begin
            mag_b_s = -b_r;
        end else begin
            mag_b_s = b_r;
        end
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_quo      (acc_r),
        .divisor      (opb_mag_r),
        .rem_quo_next (div_next_s)
    );

    // Shift-add multiply: the carry of hi+multiplicand re-enters at the top as the accumulator shifts right.
    always_comb begin
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_mag_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        if (is_div(op_r)) begin
            step_s = div_next_s;
        end else begin
            step_s = mul_next_s;
        end
    end

    // Sign restoration applied once the magnitude iteration has finished.
    always_comb begin
        if (sign_q_r) begin
            quo_fix_s = -acc_r[WIDTH-1:0];
        end else begin
            quo_fix_s = acc_r[WIDTH-1:0];
        end
        if (sign_rem_r) begin
            rem_fix_s = -acc_r[2*WIDTH-1:WIDTH];
        end else begin
            rem_fix_s = acc_r[2*WIDTH-1:WIDTH];
        end
        if (is_div(op_r)) begin
            fix_s = {rem_fix_s, quo_fix_s};
        end else if (sign_q_r) begin
            fix_s = -acc_r;
        end else begin
            fix_s = acc_r;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag_prod_s;

    // Single-cycle product of the magnitudes, sign fixed in the same cycle.
    always_comb begin
        fast_mul_s      = ~is_div(op_r);
        fast_mag_prod_s = {{WIDTH{1'b0}}, mag_a_s} * {{WIDTH{1'b0}}, mag_b_s};
        if (sign_mode_s && (a_r[WIDTH-1] ^ b_r[WIDTH-1])) begin
            fast_prod_s = -fast_mag_prod_s;
        end else begin
            fast_prod_s = fast_mag_prod_s;
        end
    end
`else
    // Iterative build: multiplies always take the RUN path.
    always_comb begin
        fast_mul_s  = 1'b0;
        fast_prod_s = {2*WIDTH{1'b0}};
    end
`endif

    // Value captured into result_o on entry to DONE; PREP only reaches DONE for div-by-zero or a fast multiply.
    always_comb begin
        if (state_r == S_PREP) begin
            if (div0_s) begin
                result_s = {a_r, {WIDTH{1'b1}}};
            end else begin
                result_s = fast_prod_s;
            end
        end else begin
            result_s = fix_s;
        end
    end

    // Next-state logic; annul wins over everything outside IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    state_s = S_PREP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PREP: begin
                if (annul_i) begin
                    state_s = S_IDLE;
                end else if (div0_s || fast_mul_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_RUN: begin
                if (annul_i) begin
                    state_s = S_IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_FIX: begin
                if (annul_i) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs; busy/done are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r       <= OP_MULTU;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            opb_mag_r  <= {WIDTH{1'b0}};
            acc_r      <= {2*WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            sign_q_r   <= 1'b0;
            sign_rem_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {2*WIDTH{1'b0}};
        end else begin
            busy_r <= (state_s != S_IDLE);
            done_r <= (state_s == S_DONE);
            if (state_s == S_DONE) begin
                result_r <= result_s;
            end
            case (state_r)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        op_r <= op_e'(op_i);
                        a_r  <= opdata1_i;
                        b_r  <= opdata2_i;
                    end
                end
                S_PREP: begin
                    sign_q_r   <= sign_mode_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    sign_rem_r <= sign_mode_s & a_r[WIDTH-1];
                    opb_mag_r  <= mag_b_s;
                    acc_r      <= {{WIDTH{1'b0}}, mag_a_s};
                    cnt_r      <= CNT_W'(WIDTH);
                end
                S_RUN: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (WIDTH=32): directed cases, randomized ops
// against an arithmetic reference model, annul, busy-start and mid-run reset.
module tb_muldiv_iter;

    localparam int W = 32;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 3;
`endif
    localparam int DIV_LAT  = W + 3;
    localparam int DIV0_LAT = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_i = 1'b0;
    logic [1:0]     op_i = 2'b00;
    logic [W-1:0]   opdata1_i = '0;
    logic [W-1:0]   opdata2_i = '0;
    logic           annul_i = 1'b0;
    logic           busy_o, done_o;
    logic [2*W-1:0] result_o;

    int             total = 0;
    int             bad = 0;
    logic [2*W-1:0] last_res = '0;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, {hi,lo}
    function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint         sa, sb, q, r;
        logic [2*W-1:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = {32'd0, a} * {32'd0, b};
            2'b01: res = sa * sb;
            2'b10: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
        if (op[1] == 1'b0) return MUL_LAT;
        if (b == 0) return DIV0_LAT;
        return DIV_LAT;
    endfunction

    // Issue one op (called just after a rising edge); reports edges to done, result, busy profile.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [2*W-1:0] res, output bit busy_ok);
        op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        lat = 0; res = '0; busy_ok = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (done_o === 1'b1) begin
                lat = n;
                res = result_o;
                break;
            end
        end
        @(posedge clk); #1;
        if (busy_o !== 1'b0 || done_o !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b result=%h, want 0 0 0", busy_o, done_o, result_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]     ops [7]  = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
        logic [W-1:0]   as  [7]  = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd7};
        logic [W-1:0]   bs  [7]  = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [2*W-1:0] exp [7]  = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000},
                                     {32'd5, 32'hFFFF_FFFF}, 64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001,
                                     {32'd1, 32'hFFFF_FFFD}};
        int             lat;
        logic [2*W-1:0] res;
        bit             bok;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res, bok);
            total++;
            if (res !== exp[i]) begin
                bad++;
                $display("FAIL directed[%0d] result: got %h want %h", i, res, exp[i]);
            end
            total++;
            if (lat !== exp_lat(ops[i], bs[i])) begin
                bad++;
                $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, exp_lat(ops[i], bs[i]));
            end
            total++;
            if (bok !== 1'b1) begin
                bad++;
                $display("FAIL directed[%0d] busy profile: got %b want 1", i, bok);
            end
            last_res = exp[i];
        end
    endtask

    task automatic test_random();
        int             lat;
        logic [2*W-1:0] res, exp;
        bit             bok;
        logic [1:0]     op;
        logic [W-1:0]   a, b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd1;
                3:       b = 32'($urandom_range(2, 300));
                default: b = $urandom;
            endcase
            exp = model(op, a, b);
            do_op(op, a, b, lat, res, bok);
            total++;
            if (res !== exp || lat !== exp_lat(op, b) || bok !== 1'b1) begin
                bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat=%0d busy=%b want %h lat=%0d",
                         i, op, a, b, res, lat, bok, exp, exp_lat(op, b));
            end
            last_res = exp;
        end
    endtask

    task automatic test_annul();
        int             lat;
        logic [2*W-1:0] res;
        bit             bok;
        bit             saw_done = 1'b0;
        // annul together with start in IDLE suppresses the start
        op_i = 2'b10; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        start_i = 1'b1; annul_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL annul_idle: busy=%b want 0", busy_o);
        end
        // annul mid-RUN: start sampled at edge 1, annul asserted after edge 10
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int e = 2; e <= 10; e++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) saw_done = 1'b1;
        end
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || saw_done || result_o !== last_res) begin
            bad++;
            $display("FAIL annul_run: busy=%b done=%b early_done=%b result=%h want 0 0 0 %h",
                     busy_o, done_o, saw_done, result_o, last_res);
        end
        do_op(2'b10, 32'd1000, 32'd3, lat, res, bok);
        total++;
        if (res !== {32'd1, 32'd333} || lat !== DIV_LAT || bok !== 1'b1) begin
            bad++;
            $display("FAIL annul_restart: got %h lat=%0d busy=%b want %h lat=%0d",
                     res, lat, bok, {32'd1, 32'd333}, DIV_LAT);
        end
        last_res = {32'd1, 32'd333};
    endtask

    task automatic test_back_to_back();
        int             lat = 0;
        logic [2*W-1:0] res = '0;
        // first op DIVU 50/6; start stays high with a different request while busy
        op_i = 2'b10; opdata1_i = 32'd50; opdata2_i = 32'd6; start_i = 1'b1;
        @(posedge clk); #1;
        op_i = 2'b01; opdata1_i = 32'hFFFF_FFFE; opdata2_i = 32'd9;
        for (int n = 2; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                lat = n;
                res = result_o;
                break;
            end
        end
        total++;
        if (res !== {32'd2, 32'd8} || lat !== DIV_LAT) begin
            bad++;
            $display("FAIL busy_start_ignored: got %h lat=%0d want %h lat=%0d", res, lat, {32'd2, 32'd8}, DIV_LAT);
        end
        @(posedge clk); #1;
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_done: busy=%b want 0", busy_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL start_after_done: busy=%b want 1", busy_o);
        end
        lat = 0; res = '0;
        for (int n = 2; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                lat = n;
                res = result_o;
                break;
            end
        end
        total++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFEE || lat !== MUL_LAT) begin
            bad++;
            $display("FAIL second_op: got %h lat=%0d want %h lat=%0d", res, lat, 64'hFFFF_FFFF_FFFF_FFEE, MUL_LAT);
        end
        last_res = 64'hFFFF_FFFF_FFFF_FFEE;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        bit saw = 1'b0;
        op_i = 2'b11; opdata1_i = 32'd12345; opdata2_i = 32'd17; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b done=%b result=%h want 0 0 0", busy_o, done_o, result_o);
        end
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done_o !== 1'b0 || busy_o !== 1'b0) saw = 1'b1;
        end
        total++;
        if (saw) begin
            bad++;
            $display("FAIL reset_mid_run_quiet: activity=%b want 0", saw);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised multi-cycle multiply/divide unit for the execute stage; successor to the fixed 32-bit divider the ALU drives today.
- Handles signed/unsigned multiply and divide with one start/done handshake and annul support.
- Returns a packed {hi,lo} result that the ALU forwards to the HILO write path.
- The ALU holds the pipeline stalled while busy_o is high.

Parameters:
- WIDTH, 32: operand width in bits. Must be even and ≥ 4.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  request; sampled only in IDLE
- op_i  in  2  operation: MULTU / MULT / DIVU / DIV
- opdata1_i  in  WIDTH  multiplicand / dividend
- opdata2_i  in  WIDTH  multiplier / divisor
- annul_i  in  1  abort the current operation
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse; result_o is valid and new
- result_o  out  2*WIDTH  {hi,lo}: product, or {remainder, quotient}

Behaviour:
- Clocking/reset:
  - Single clock clk; reset rst is synchronous, active-high.
  - Reset → state IDLE, busy_o=0, done_o=0, result_o=0, counter=0.
  - Reset mid-operation discards the operation with no done_o.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - start_i=1 and annul_i=0 → latch op_i and both operands; go to PREP.
  - annul_i=1 in the same cycle suppresses the start.
- PREP (1 cycle):
  - For signed ops, form magnitudes; record sign_q = a[W-1]^b[W-1] and sign_r = a[W-1].
  - Divide with divisor==0 → go to DONE directly.
  - Otherwise go to RUN with counter=WIDTH.
- RUN (WIDTH cycles):
  - Divide: one restoring radix-2 step per cycle.
    - Shift {rem, quo} left by 1.
    - If rem ≥ divisor: subtract divisor and set quo LSB.
  - Multiply: one shift-add step per cycle over the 2W accumulator.
  - Counter decrements each cycle; at 1 → FIX.
- FIX (1 cycle):
  - Signed ops: negate the quotient if sign_q; negate the remainder if sign_r.
  - Signed multiply: negate the full 2W product if sign_q.
- DONE (1 cycle):
  - result_o updated, done_o=1, then return to IDLE.
- Latency:
  - Normal ops: done_o is high in the cycle WIDTH+3 edges after the start-sampling edge (35 for WIDTH=32).
  - Divide by zero: done_o after 2 edges.
- Divide by zero: lo = all ones; hi = dividend unmodified (raw opdata1_i), for both DIV and DIVU.
- Signed overflow (DIV of MIN by −1):
  - Falls out of the magnitude algorithm: quotient = MIN, remainder = 0.
  - No flag is raised.
- result_o:
  - Written only on entry to DONE.
  - Holds its value until the next DONE, including across annul.
- annul_i in PREP/RUN/FIX/DONE → IDLE on the next edge.
  - No done_o; busy_o falls on the same edge.
  - An annul sampled in DONE still lets that cycle's done_o pulse stand (the result is already written).
- Handshake:
  - start_i while busy_o=1 is ignored; no queuing.
  - A new start is accepted in the cycle after DONE (IDLE).

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops compute the product combinationally from the magnitudes in PREP, including the sign fix.
  - They go PREP→DONE, so latency is 2 edges.
  - RUN/FIX are used by divides only.
- Undefined:
  - Multiply uses the iterative RUN path.
  - Latency matches divide (WIDTH+3); no WIDTH×WIDTH multiplier is inferred.
- Divide behaviour is identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULTU=2'b00, OP_MULT=2'b01, OP_DIVU=2'b10, OP_DIV=2'b11;
  - state encodings.
- Sub-module div_step (combinational, parametrised by WIDTH):
  - inputs {rem,quo}, divisor;
  - output the next {rem,quo} for one restoring step.
  - It is instantiated once in RUN and unit-testable alone.

Test Plan (WIDTH=32):
- DIVU 100/7 → done_o at edge 35, result_o = {32'd2, 32'd14}; busy_o high edges 1–35.
- DIV 0xFFFFFFF9 (−7) / 2 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0; DIVU 5/0 → lo = 0xFFFFFFFF, hi = 5, done_o at edge 2.
- MULT 0xFFFFFFFD × 5 → 0xFFFFFFFF_FFFFFFF1; MULTU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001.
  - Latency 35 without the macro, 2 with it.
- DIVU started, annul_i at edge 10 → busy_o=0 at edge 11, no done_o, result_o unchanged; a start at edge 11 is accepted normally.
- start_i held high while busy → ignored; rst asserted mid-RUN → IDLE, outputs 0, no done_o.
